io_bus_interconnect: RTL and testbench



---
 rtl/io_bus_pkg.sv | 16 +
 rtl/io_addr_decoder.sv | 33 +++
 rtl/io_bus_interconnect.sv | 192 +++++++++++++++++++
 tb/tb_io_bus_interconnect.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the memory-mapped I/O interconnect.
package io_bus_pkg;

    // Upper bound on the number of slave regions the decoder supports.
    localparam int MAX_REGIONS = 8;

    // Read data handed back to the processor when a slave never answers.
    localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;

    // Bus FSM: IDLE accepts new requests, WAIT holds a stalled access.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

endpackage : io_bus_pkg

// File: rtl/io_addr_decoder.sv
// Combinational priority address decoder: the lowest-index hitting region wins.
module io_addr_decoder
    import io_bus_pkg::*;
#(
    parameter int                        NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = '0
) (
    input  logic [31:0]            address_i,
    output logic [NUM_REGIONS-1:0] hit_o,
    output logic                   any_hit_o
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS) begin : g_bad_regions
        $error("io_addr_decoder: NUM_REGIONS out of range");
    end

    // Scan regions from index 0 upward; a zero mask disables a region, and the
    // first match blocks all later ones so overlapping windows resolve low-first.
    always_comb begin
        hit_o     = '0;
        any_hit_o = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!any_hit_o &&
                (REGION_MASK[i*32 +: 32] != 32'h0) &&
                ((address_i & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32])) begin
                hit_o[i]  = 1'b1;
                any_hit_o = 1'b1;
            end
        end
    end

endmodule : io_addr_decoder

// File: rtl/io_bus_interconnect.sv
// Multi-region I/O interconnect: decodes the processor data port onto
// per-slave selects, stalls on wait states, aborts on timeout and reports errors.
module io_bus_interconnect
    import io_bus_pkg::*;
#(
    parameter int                        NUM_REGIONS    = 4,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE    = {32'h0000_0000, 32'h0000_0000,
                                                           32'h0000_8000, 32'h0000_7f00},
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK    = {32'h0000_0000, 32'h0000_0000,
                                                           32'hFFFF_8000, 32'hFFFF_FF00},
    parameter int                        TIMEOUT_CYCLES = 16,
    parameter logic [31:0]               ERROR_DATA     = DEFAULT_ERROR_DATA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               address,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [31:0]               io_memory_write,
    output logic [31:0]               io_memory_read,
    output logic                      io_valid_data,
    output logic                      stall,
    output logic                      bus_error,
    output logic [31:0]               error_address,
    output logic [7:0]                error_count,
    output logic [NUM_REGIONS-1:0]    s_sel,
    output logic                      s_read,
    output logic                      s_write,
    output logic [31:0]               s_address,
    output logic [31:0]               s_write_data,
    input  logic [NUM_REGIONS*32-1:0] s_read_data,
    input  logic [NUM_REGIONS-1:0]    s_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_t             state_q, state_d;
    logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [31:0]            read_q, read_d;
    logic                   valid_q, valid_d;
    logic                   bus_error_q, bus_error_d;
    logic [31:0]            err_addr_q, err_addr_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic [NUM_REGIONS-1:0] hit;
    logic                   any_hit;
    logic [NUM_REGIONS-1:0] sel;
    logic                   request;
    logic                   conflict;
    logic                   is_read;
    logic                   mapped_req;
    logic                   ready;
    logic                   timeout;
    logic                   err_event;
    logic [31:0]            sel_data;

    io_addr_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decoder (
        .address_i (address),
        .hit_o     (hit),
        .any_hit_o (any_hit)
    );

    assign request    = MemRead | MemWrite;
    assign conflict   = MemRead & MemWrite;
    assign is_read    = MemRead & ~MemWrite;
    assign mapped_req = !rst && (state_q == IDLE) && request && any_hit;

    // Active select: fresh decode in IDLE, the registered select while waiting
    // so a slave keeps seeing the same access for its whole duration.
    always_comb begin
        sel = '0;
        if (rst) begin
            sel = '0;
        end else if (state_q == IDLE) begin
            sel = mapped_req ? hit : '0;
        end else begin
            sel = sel_q;
        end
    end

    assign ready   = |(sel & s_ready);
    assign timeout = (state_q == WAIT) && !ready && (wait_cnt_q == CW'(TIMEOUT_CYCLES));
    assign stall   = (mapped_req && !ready) ||
                     (!rst && (state_q == WAIT) && !ready && !timeout);

    assign s_sel        = sel;
    assign s_read       = (|sel) & is_read;
    assign s_write      = (|sel) & MemWrite;
    assign s_address    = address;
    assign s_write_data = io_memory_write;

    // One-hot read-data mux from the selected slave.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel[i]) begin
                sel_data = sel_data | s_read_data[i*32 +: 32];
            end
        end
    end

    // Next-state logic: IDLE parks stalled accesses in WAIT, WAIT leaves on
    // completion or once the wait counter reaches the timeout limit.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sel_d      = sel_q;
        unique case (state_q)
            IDLE: begin
                if (mapped_req && !ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = CW'(1);
                    sel_d      = hit;
                end
            end
            WAIT: begin
                if (ready || timeout) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    sel_d      = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
                sel_d      = '0;
            end
        endcase
    end

    // Read return path and error bookkeeping: completed reads return slave data,
    // aborted reads return the error pattern; timeouts and read/write conflicts
    // raise a one-cycle error pulse and are counted with saturation.
    always_comb begin
        read_d      = read_q;
        valid_d     = 1'b0;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;
        err_event   = timeout || (mapped_req && conflict);
        bus_error_d = err_event;
        if (ready && is_read) begin
            read_d  = sel_data;
            valid_d = 1'b1;
        end else if (timeout && is_read) begin
            read_d  = ERROR_DATA;
            valid_d = 1'b1;
        end
        if (err_event) begin
            err_addr_d = address;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            sel_q       <= '0;
            read_q      <= '0;
            valid_q     <= 1'b0;
            bus_error_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            sel_q       <= sel_d;
            read_q      <= read_d;
            valid_q     <= valid_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign io_memory_read = read_q;
    assign io_valid_data  = valid_q;
    assign bus_error      = bus_error_q;
    assign error_address  = err_addr_q;
    assign error_count    = err_cnt_q;

endmodule : io_bus_interconnect

// File: tb/tb_io_bus_interconnect.sv
// Directed testbench for io_bus_interconnect: table-driven zero-wait accesses
// plus hand-written wait-state, timeout, reset and saturation sequences.
module tb_io_bus_interconnect;

    localparam int NR = 4;

    logic           clk;
    logic           rst;
    logic [31:0]    address;
    logic           MemRead;
    logic           MemWrite;
    logic [31:0]    io_memory_write;
    logic [31:0]    io_memory_read;
    logic           io_valid_data;
    logic           stall;
    logic           bus_error;
    logic [31:0]    error_address;
    logic [7:0]     error_count;
    logic [NR-1:0]  s_sel;
    logic           s_read;
    logic           s_write;
    logic [31:0]    s_address;
    logic [31:0]    s_write_data;
    logic [NR*32-1:0] s_read_data;
    logic [NR-1:0]  s_ready;

    int total = 0;
    int bad   = 0;

    io_bus_interconnect #(
        .NUM_REGIONS    (NR),
        .REGION_BASE    ({32'h0001_0000, 32'h0000_7000, 32'h0000_8000, 32'h0000_7f00}),
        .REGION_MASK    ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_8000, 32'hFFFF_FF00}),
        .TIMEOUT_CYCLES (16),
        .ERROR_DATA     (32'hDEAD_BEEF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .address         (address),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .io_memory_write (io_memory_write),
        .io_memory_read  (io_memory_read),
        .io_valid_data   (io_valid_data),
        .stall           (stall),
        .bus_error       (bus_error),
        .error_address   (error_address),
        .error_count     (error_count),
        .s_sel           (s_sel),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_address       (s_address),
        .s_write_data    (s_write_data),
        .s_read_data     (s_read_data),
        .s_ready         (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  rdy;
        int          region;
        logic [31:0] data;
        logic [3:0]  expSel;
        logic        expStall;
        logic        expSRd;
        logic        expSWr;
        logic        expValid;
        logic [31:0] expRead;
        logic        expErr;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Selected region gets the given data, every other slave drives a distinct junk word.
    task automatic setSlaves(input int region, input logic [31:0] data);
        for (int k = 0; k < NR; k++) begin
            s_read_data[k*32 +: 32] = (k == region) ? data : (32'hBAD0_0000 | 32'(k));
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic rd, input logic wr,
                                 input logic [31:0] wd);
        address         = a;
        MemRead         = rd;
        MemWrite        = wr;
        io_memory_write = wd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int stallCnt;
    int expErrCnt;

    initial begin
        vecs[0] = '{32'h0000_7f04, 1'b1, 1'b0, 4'b0001, 0, 32'h0000_1234,
                    4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
        vecs[1] = '{32'h0000_2000, 1'b1, 1'b0, 4'b1111, 0, 32'h0000_5555,
                    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_7f08, 1'b1, 1'b0, 4'b0101, 0, 32'hCAFE_0008,
                    4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_0008, 1'b0};
        vecs[3] = '{32'h0000_8010, 1'b1, 1'b0, 4'b0010, 1, 32'hA5A5_0001,
                    4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0};
        vecs[4] = '{32'h0001_0020, 1'b1, 1'b0, 4'b1000, 3, 32'h3333_0020,
                    4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3333_0020, 1'b0};
        vecs[5] = '{32'h0000_7004, 1'b1, 1'b0, 4'b0100, 2, 32'h2222_0004,
                    4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_0004, 1'b0};
        vecs[6] = '{32'h0000_7f00, 1'b0, 1'b1, 4'b0001, 0, 32'h0,
                    4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{32'h0000_7f08, 1'b1, 1'b1, 4'b0001, 0, 32'h7777_0000,
                    4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};

        // Reset with a live mapped request: everything must read zero.
        rst     = 1'b1;
        s_ready = 4'b0001;
        setSlaves(0, 32'h0000_1234);
        applyStimulus(32'h0000_7f04, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("rst_read",  io_memory_read, 32'h0);
        checkOutput("rst_valid", {31'h0, io_valid_data}, 32'h0);
        checkOutput("rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("rst_sel",   {28'h0, s_sel}, 32'h0);
        checkOutput("rst_err",   {31'h0, bus_error}, 32'h0);
        checkOutput("rst_ecnt",  {24'h0, error_count}, 32'h0);
        checkOutput("rst_eaddr", error_address, 32'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        nextCycle();
        expErrCnt = 0;

        // Read with three wait states; region 0 ready must be ignored.
        applyStimulus(32'h0000_8010, 1'b1, 1'b0, 32'h0);
        setSlaves(1, 32'hA5A5_0001);
        stallCnt = 0;
        for (int k = 0; k < 40; k++) begin
            s_ready = (stallCnt >= 3) ? 4'b0011 : 4'b0001;
            #1;
            if (!stall) break;
            stallCnt++;
            nextCycle();
        end
        checkOutput("wait3_stalls", 32'(stallCnt), 32'd3);
        checkOutput("wait3_sel", {28'h0, s_sel}, 32'h2);
        nextCycle();
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        s_ready = 4'b0000;
        checkOutput("wait3_valid", {31'h0, io_valid_data}, 32'h1);
        checkOutput("wait3_data",  io_memory_read, 32'hA5A5_0001);
        nextCycle();
        checkOutput("wait3_valid_once", {31'h0, io_valid_data}, 32'h0);

        // Write that times out after sixteen stall cycles.
        applyStimulus(32'h0000_7f00, 1'b0, 1'b1, 32'h0000_00FF);
        s_ready  = 4'b0000;
        stallCnt = 0;
        #1;
        checkOutput("to_wdata", s_write_data, 32'h0000_00FF);
        checkOutput("to_saddr", s_address, 32'h0000_7f00);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall) break;
            stallCnt++;
            nextCycle();
        end
        checkOutput("to_stalls", 32'(stallCnt), 32'd16);
        checkOutput("to_err_early", {31'h0, bus_error}, 32'h0);
        nextCycle();
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        expErrCnt++;
        checkOutput("to_err",   {31'h0, bus_error}, 32'h1);
        checkOutput("to_eaddr", error_address, 32'h0000_7f00);
        checkOutput("to_ecnt",  {24'h0, error_count}, 32'(expErrCnt));
        checkOutput("to_valid", {31'h0, io_valid_data}, 32'h0);
        nextCycle();
        checkOutput("to_err_pulse", {31'h0, bus_error}, 32'h0);

        // Zero-wait table: decode, priority, strobes and read return.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].rd, vecs[v].wr, 32'h0000_0042);
            s_ready = vecs[v].rdy;
            setSlaves(vecs[v].region, vecs[v].data);
            #1;
            checkOutput($sformatf("v%0d_sel", v),   {28'h0, s_sel}, {28'h0, vecs[v].expSel});
            checkOutput($sformatf("v%0d_stall", v), {31'h0, stall}, {31'h0, vecs[v].expStall});
            checkOutput($sformatf("v%0d_srd", v),   {31'h0, s_read}, {31'h0, vecs[v].expSRd});
            checkOutput($sformatf("v%0d_swr", v),   {31'h0, s_write}, {31'h0, vecs[v].expSWr});
            nextCycle();
            checkOutput($sformatf("v%0d_valid", v), {31'h0, io_valid_data}, {31'h0, vecs[v].expValid});
            checkOutput($sformatf("v%0d_err", v),   {31'h0, bus_error}, {31'h0, vecs[v].expErr});
            if (vecs[v].expValid) begin
                checkOutput($sformatf("v%0d_data", v), io_memory_read, vecs[v].expRead);
            end
            if (vecs[v].expErr) expErrCnt++;
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        s_ready = 4'b0000;
        checkOutput("conf_ecnt",  {24'h0, error_count}, 32'(expErrCnt));
        checkOutput("conf_eaddr", error_address, 32'h0000_7f08);
        nextCycle();

        // Read that times out returns the error pattern alongside the error pulse.
        applyStimulus(32'h0000_8020, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall) break;
            nextCycle();
        end
        nextCycle();
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        expErrCnt++;
        checkOutput("tor_valid", {31'h0, io_valid_data}, 32'h1);
        checkOutput("tor_data",  io_memory_read, 32'hDEAD_BEEF);
        checkOutput("tor_err",   {31'h0, bus_error}, 32'h1);
        checkOutput("tor_ecnt",  {24'h0, error_count}, 32'(expErrCnt));
        nextCycle();

        // Reset on the second WAIT cycle aborts silently.
        applyStimulus(32'h0000_8010, 1'b1, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("rstw_stall", {31'h0, stall}, 32'h0);
        checkOutput("rstw_sel",   {28'h0, s_sel}, 32'h0);
        checkOutput("rstw_ecnt",  {24'h0, error_count}, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("rstw_valid", {31'h0, io_valid_data}, 32'h0);
        checkOutput("rstw_err",   {31'h0, bus_error}, 32'h0);

        // 300 back-to-back forced timeouts saturate the counter.
        applyStimulus(32'h0000_7f00, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 300 * 17; k++) begin
            nextCycle();
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("sat_ecnt", {24'h0, error_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_io_bus_interconnect
